// File: rtl/esc_pkg.sv
// Shared types and constants for the register-port arbiter slice.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package esc_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_t;

   // Supported register-file read latency window
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Width of the RD_WAIT down-counter, sized for the slowest register file
   localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

   // Master IDs: m0 is the I2C slave, m1 the autotune/telemetry master
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Owner and direction of the access currently in flight
   typedef struct packed {
      logic owner;
      logic we;
   } acc_ctl_t;

   // Pins an out-of-range read latency to the nearest supported value so the
   // counter always has a defined load value.
   function automatic logic [CNT_W-1:0] rd_lat_clamp(input int lat);
      logic [CNT_W-1:0] v;
      if (lat < RD_LAT_MIN) begin
         v = CNT_W'(RD_LAT_MIN);
      end else if (lat > RD_LAT_MAX) begin
         v = CNT_W'(RD_LAT_MAX);
      end else begin
         v = CNT_W'(lat);
      end
      return v;
   endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-master round-robin grant decision with an m0 burst lock.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only consumes the grant while it is idle.
module rr_grant2
   import esc_pkg::*;
(
   input  logic i_m0_req,
   input  logic i_m1_req,
   input  logic i_m0_lock,
   input  logic i_last_gnt,
   output logic o_gnt_vld,
   output logic o_gnt_id
);

   logic w_m0_hold;
   logic w_m1_ok;

   // m0 keeps the port while it holds the lock and owned the last access,
   // even across gaps where its req is low.
   assign w_m0_hold = i_m0_lock & (i_last_gnt == M0);
   assign w_m1_ok   = i_m1_req & ~w_m0_hold;

   // Pick a winner: single requester wins, a tie goes to the master not served last
   always_comb begin
      o_gnt_vld = i_m0_req | w_m1_ok;
      o_gnt_id  = M0;
      if (i_m0_req && w_m1_ok) begin
         o_gnt_id = (i_last_gnt == M0) ? M1 : M0;
      end else if (w_m1_ok) begin
         o_gnt_id = M1;
      end
   end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares one register-file port between the I2C slave (m0) and the internal master (m1).
// Latency: grant to ack is 2 cycles for writes, 2 + RD_LAT cycles for reads.
// Backpressure: req is held until ack; a loser simply waits, one access in flight at a time.
module reg_port_arbiter
   import esc_pkg::*;
#(
   parameter int IDX_W  = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   // master 0 (I2C slave)
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [IDX_W-1:0]  m0_index,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_lock,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   // master 1 (autotune / telemetry)
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [IDX_W-1:0]  m1_index,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   // register-file port
   output logic              write,
   output logic              read_1,
   output logic [IDX_W-1:0]  index_1,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out_1,
   // status
   output logic              busy
);

   localparam logic [CNT_W-1:0] RD_LAT_C = rd_lat_clamp(RD_LAT);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   acc_ctl_t          r_acc;
   logic              r_last_gnt;
   logic [IDX_W-1:0]  r_index;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   logic              w_gnt_vld;
   logic              w_gnt_id;
   logic              w_take;
   logic              w_rd_last;
   logic              w_sel_we;
   logic [IDX_W-1:0]  w_sel_index;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_grant2 u_rr_grant2 (
      .i_m0_req   (m0_req),
      .i_m1_req   (m1_req),
      .i_m0_lock  (m0_lock),
      .i_last_gnt (r_last_gnt),
      .o_gnt_vld  (w_gnt_vld),
      .o_gnt_id   (w_gnt_id)
   );

   // Ports are only looked at in IDLE; elsewhere the registered access drives everything
   assign w_take    = (r_state == ST_IDLE) & w_gnt_vld;
   assign w_rd_last = (r_state == ST_RD_WAIT) & (r_cnt == CNT_W'(1));

   // Route the winning master's request fields toward the access register
   always_comb begin
      w_sel_we    = m0_we;
      w_sel_index = m0_index;
      w_sel_wdata = m0_wdata;
      if (w_gnt_id == M1) begin
         w_sel_we    = m1_we;
         w_sel_index = m1_index;
         w_sel_wdata = m1_wdata;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_gnt_vld) w_state_nxt = ST_ISSUE;
         ST_ISSUE:   w_state_nxt = r_acc.we ? ST_DONE : ST_RD_WAIT;
         ST_RD_WAIT: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Read-latency down-counter: loaded alongside the read strobe, drained in RD_WAIT
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if ((r_state == ST_ISSUE) && !r_acc.we) begin
         r_cnt <= RD_LAT_C;
      end else if (r_state == ST_RD_WAIT) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Access register and last-grant memory, captured only on a grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc      <= '0;
         r_last_gnt <= M1;
         r_index    <= '0;
         r_wdata    <= '0;
      end else if (w_take) begin
         r_acc.owner <= w_gnt_id;
         r_acc.we    <= w_sel_we;
         r_last_gnt  <= w_gnt_id;
         r_index     <= w_sel_index;
         // reads leave the write-data bus untouched so the register file sees no toggling
         if (w_sel_we) begin
            r_wdata <= w_sel_wdata;
         end
      end
   end

   // Per-master read data, captured on the cycle the register file output is valid
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else if (w_rd_last) begin
         if (r_acc.owner == M0) begin
            r_m0_rdata <= data_out_1;
         end else begin
            r_m1_rdata <= data_out_1;
         end
      end
   end

   // FSM output decode: strobes and acks are pure functions of state and owner
   always_comb begin
      write  = (r_state == ST_ISSUE) &  r_acc.we;
      read_1 = (r_state == ST_ISSUE) & ~r_acc.we;
      m0_ack = (r_state == ST_DONE)  & (r_acc.owner == M0);
      m1_ack = (r_state == ST_DONE)  & (r_acc.owner == M1);
      busy   = (r_state != ST_IDLE);
   end

   assign index_1  = r_index;
   assign data_in  = r_wdata;
   assign m0_rdata = r_m0_rdata;
   assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with RD_LAT=2 and a small register-file model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       m0_req, m0_we, m0_lock, m0_ack;
   logic [7:0] m0_index, m0_wdata, m0_rdata;
   logic       m1_req, m1_we, m1_ack;
   logic [7:0] m1_index, m1_wdata, m1_rdata;
   logic       write, read_1, busy;
   logic [7:0] index_1, data_in, data_out_1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_both_strobe = 0;
   int n_both_ack    = 0;

   always #5 clk = ~clk;

   reg_port_arbiter #(.IDX_W(8), .DATA_W(8), .RD_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_req     (m0_req),
      .m0_we      (m0_we),
      .m0_index   (m0_index),
      .m0_wdata   (m0_wdata),
      .m0_lock    (m0_lock),
      .m0_ack     (m0_ack),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_index   (m1_index),
      .m1_wdata   (m1_wdata),
      .m1_ack     (m1_ack),
      .m1_rdata   (m1_rdata),
      .write      (write),
      .read_1     (read_1),
      .index_1    (index_1),
      .data_in    (data_in),
      .data_out_1 (data_out_1),
      .busy       (busy)
   );

   // Register-file model: writes land at the edge, read data valid RD_LAT=2 cycles after read_1
   logic [7:0] mem [0:255];
   logic [7:0] rd_pipe0, rd_pipe1;
   always @(posedge clk) begin
      if (!rst) mem[8'h48] <= 8'hC3;
      if (write) mem[index_1] <= data_in;
      rd_pipe0 <= read_1 ? mem[index_1] : 8'h00;
      rd_pipe1 <= rd_pipe0;
   end
   assign data_out_1 = rd_pipe1;

   // Exclusivity monitor over the whole run
   always @(negedge clk) begin
      if (write && read_1) n_both_strobe <= n_both_strobe + 1;
      if (m0_ack && m1_ack) n_both_ack <= n_both_ack + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // {busy, write, read_1, m0_ack, m1_ack}
   function automatic logic [4:0] ctl();
      return {busy, write, read_1, m0_ack, m1_ack};
   endfunction

   logic [4:0] rd_exp   [0:4]  = '{5'b10100, 5'b10000, 5'b10000, 5'b10001, 5'b00000};
   logic [4:0] drp_exp  [0:4]  = '{5'b10100, 5'b10000, 5'b10000, 5'b10010, 5'b00000};
   logic [4:0] alt_exp  [0:14] = '{5'b11000, 5'b10010, 5'b00000, 5'b10100, 5'b10000,
                                   5'b10000, 5'b10001, 5'b00000, 5'b11000, 5'b10010,
                                   5'b00000, 5'b10100, 5'b10000, 5'b10000, 5'b10001};
   logic [4:0] lock_exp [0:13] = '{5'b11000, 5'b10010, 5'b00000, 5'b00000, 5'b11000,
                                   5'b10010, 5'b00000, 5'b11000, 5'b10010, 5'b00000,
                                   5'b10100, 5'b10000, 5'b10000, 5'b10001};
   logic [4:0] rst2_exp [0:6]  = '{5'b11000, 5'b10010, 5'b00000, 5'b10100, 5'b10000,
                                   5'b10000, 5'b10001};

   initial begin
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_index = 0; m0_wdata = 0; m0_lock = 0;
      m1_req = 0; m1_we = 0; m1_index = 0; m1_wdata = 0;

      // reset state
      repeat (3) cyc();
      chk("rst_ctl", 32'(ctl()), 32'h0);
      chk("rst_index_1", 32'(index_1), 32'h0);
      chk("rst_data_in", 32'(data_in), 32'h0);
      chk("rst_m0_rdata", 32'(m0_rdata), 32'h0);
      chk("rst_m1_rdata", 32'(m1_rdata), 32'h0);
      rst = 1'b1;
      cyc();

      // m0 write 0x41 <- 0x5A
      m0_req = 1; m0_we = 1; m0_index = 8'h41; m0_wdata = 8'h5A;
      cyc();
      chk("wr_strobe", 32'(ctl()), 32'b11000);
      chk("wr_index", 32'(index_1), 32'h41);
      chk("wr_data", 32'(data_in), 32'h5A);
      cyc();
      chk("wr_ack", 32'(ctl()), 32'b10010);
      m0_req = 0;
      cyc();
      chk("wr_idle", 32'(ctl()), 32'h0);
      chk("wr_hold_index", 32'(index_1), 32'h41);
      chk("wr_hold_data", 32'(data_in), 32'h5A);
      chk("wr_mem", 32'(mem[8'h41]), 32'h5A);

      // m1 read 0x48 -> 0xC3, ack 4 cycles after grant
      m1_req = 1; m1_we = 0; m1_index = 8'h48;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("rd_k%0d", k), 32'(ctl()), 32'(rd_exp[k-1]));
         if (k == 1) chk("rd_index", 32'(index_1), 32'h48);
         if (k == 4) begin
            chk("rd_m1_rdata", 32'(m1_rdata), 32'hC3);
            m1_req = 0;
         end
      end

      // m0 read whose req drops right after grant still completes
      m0_req = 1; m0_we = 0; m0_index = 8'h41;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("drop_k%0d", k), 32'(ctl()), 32'(drp_exp[k-1]));
         if (k == 1) begin
            m0_req = 0; m0_index = 8'hFF;
         end
         if (k == 4) chk("drop_m0_rdata", 32'(m0_rdata), 32'h5A);
      end

      // both requesting continuously after reset: m0, m1, m0, m1
      rst = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      m0_req = 1; m0_we = 1; m0_index = 8'h41; m0_wdata = 8'h77;
      m1_req = 1; m1_we = 0; m1_index = 8'h41;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         chk($sformatf("alt_k%0d", k), 32'(ctl()), 32'(alt_exp[k-1]));
         if (k == 1) begin
            chk("alt_data_in", 32'(data_in), 32'h77);
            m0_wdata = 8'h88;
         end
         if (k == 7)  chk("alt_m1_rdata1", 32'(m1_rdata), 32'h77);
         if (k == 15) begin
            chk("alt_m1_rdata2", 32'(m1_rdata), 32'h88);
            m0_req = 0; m1_req = 0;
         end
      end
      cyc();

      // m0 lock across three writes keeps m1 out, even through m0_req gaps
      m0_lock = 1; m0_req = 1; m0_we = 1; m0_index = 8'h30; m0_wdata = 8'h01;
      m1_req = 1; m1_we = 0; m1_index = 8'h48;
      for (int k = 1; k <= 14; k++) begin
         cyc();
         chk($sformatf("lock_k%0d", k), 32'(ctl()), 32'(lock_exp[k-1]));
         case (k)
            2, 6: m0_req = 0;
            4, 7: m0_req = 1;
            9: begin m0_req = 0; m0_lock = 0; end
            14: begin
               chk("lock_m1_rdata", 32'(m1_rdata), 32'hC3);
               m1_req = 0;
            end
            default: ;
         endcase
      end
      cyc();

      // reset in RD_WAIT of an m0 read abandons it
      m0_req = 1; m0_we = 0; m0_index = 8'h41;
      cyc();
      chk("rst_rd_issue", 32'(ctl()), 32'b10100);
      cyc();
      chk("rst_rd_wait", 32'(ctl()), 32'b10000);
      rst = 1'b0; m0_req = 0;
      cyc();
      chk("rst2_ctl", 32'(ctl()), 32'h0);
      chk("rst2_index_1", 32'(index_1), 32'h0);
      chk("rst2_data_in", 32'(data_in), 32'h0);
      chk("rst2_m0_rdata", 32'(m0_rdata), 32'h0);
      chk("rst2_m1_rdata", 32'(m1_rdata), 32'h0);
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk($sformatf("rst2_noack_k%0d", k), 32'(ctl()), 32'h0);
      end
      m0_req = 1; m0_we = 1; m0_index = 8'h20; m0_wdata = 8'h11;
      m1_req = 1; m1_we = 0; m1_index = 8'h48;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         chk($sformatf("rst2_k%0d", k), 32'(ctl()), 32'(rst2_exp[k-1]));
         if (k == 1) chk("rst2_m0_first", 32'(index_1), 32'h20);
         if (k == 2) m0_req = 0;
         if (k == 7) begin
            chk("rst2_m1_rdata", 32'(m1_rdata), 32'hC3);
            m1_req = 0;
         end
      end
      cyc();

      chk("excl_strobes", 32'(n_both_strobe), 32'h0);
      chk("excl_acks", 32'(n_both_ack), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
